// File: rtl/b64_memory_8x8.sv
// Single-port flop memory: registered, write-through read data; out-of-range addresses read 0.
// Define B64_MEMORY_RESET_CLEAR_EN to make the synchronous reset also clear the array.
module b64_memory_8x8 #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    output logic [DATA_WIDTH-1:0] rddata
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rddata_q;
    logic [DATA_WIDTH-1:0] rddata_d;
    logic                  in_range;
    logic                  wr_en;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign wr_en    = we && in_range && !rst;

    always_comb begin
        rddata_d = '0;
        if (in_range) begin
            if (we) begin
                rddata_d = wrdata;
            end else begin
                rddata_d = mem_q[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rddata_q <= '0;
        end else begin
            rddata_q <= rddata_d;
        end
    end

    // Without the clear option the array has no reset at all.
    always_ff @(posedge clk) begin
`ifdef B64_MEMORY_RESET_CLEAR_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= wrdata;
        end
`else
        if (wr_en) begin
            mem_q[addr] <= wrdata;
        end
`endif
    end

    assign rddata = rddata_q;

endmodule

// File: tb/tb_b64_memory_8x8.sv
// Bench for b64_memory_8x8: DEPTH=8 and DEPTH=6 instances share one stimulus stream.
module tb_b64_memory_8x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wrdata;
    logic [7:0] rd8;
    logic [7:0] rd6;

    always #5 clk = ~clk;

    b64_memory_8x8 #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(8)) u_d8 (
        .clk(clk), .rst(rst), .we(we), .addr(addr),
        .wrdata(wrdata), .rddata(rd8)
    );

    b64_memory_8x8 #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(6)) u_d6 (
        .clk(clk), .rst(rst), .we(we), .addr(addr),
        .wrdata(wrdata), .rddata(rd6)
    );

`ifdef B64_MEMORY_RESET_CLEAR_EN
    localparam logic [7:0] RP2 = 8'h00;
    localparam logic [7:0] RP0 = 8'h00;
`else
    localparam logic [7:0] RP2 = 8'h05;
    localparam logic [7:0] RP0 = 8'h10;
`endif

    typedef struct {
        logic       r;
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] e8;
        logic [7:0] e6;
        string      nm;
    } vec_t;

    typedef struct {
        logic [7:0] e8;
        logic [7:0] e6;
        string      nm;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(logic r, logic w, logic [2:0] a,
                                logic [7:0] d, logic [7:0] e8,
                                logic [7:0] e6, string nm);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d;
        v.e8 = e8; v.e6 = e6; v.nm = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [7:0] e8, logic [7:0] e6);
        n_cmp++;
        if (rd8 !== e8) begin
            n_bad++;
            $display("FAIL %s d8: got %h want %h", nm, rd8, e8);
        end
        n_cmp++;
        if (rd6 !== e6) begin
            n_bad++;
            $display("FAIL %s d6: got %h want %h", nm, rd6, e6);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        @(negedge clk);
        rst    = v.r;
        we     = v.w;
        addr   = v.a;
        wrdata = v.d;
        e.e8 = v.e8; e.e6 = v.e6; e.nm = v.nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", v.nm);
        end else begin
            e = sbq.pop_front();
            check(e.nm, e.e8, e.e6);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; we = 1'b0; addr = '0; wrdata = '0;

        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 8'h00, 8'h00, "reset");
`ifdef B64_MEMORY_RESET_CLEAR_EN
        for (int i = 0; i < 8; i++)
            add(0, 0, 3'(i), 8'h00, 8'h00, 8'h00, "rst_clear_rd");
`endif
        add(0, 1, 0, 8'h03, 8'h03, 8'h03, "wr0");
        add(0, 1, 1, 8'h04, 8'h04, 8'h04, "wr1");
        add(0, 1, 2, 8'h05, 8'h05, 8'h05, "wr2");
        add(0, 1, 3, 8'h06, 8'h06, 8'h06, "wr3");
        add(0, 0, 0, 8'hFF, 8'h03, 8'h03, "rd0");
        add(0, 0, 1, 8'hFF, 8'h04, 8'h04, "rd1");
        add(0, 0, 2, 8'hFF, 8'h05, 8'h05, "rd2");
        add(0, 0, 3, 8'hFF, 8'h06, 8'h06, "rd3");
        add(0, 1, 3, 8'h07, 8'h07, 8'h07, "ovw3");
        add(0, 0, 3, 8'h00, 8'h07, 8'h07, "ovw_rd3");
        add(0, 0, 1, 8'h00, 8'h04, 8'h04, "ovw_rd1");
        add(0, 0, 0, 8'h00, 8'h03, 8'h03, "ovw_rd0");
        add(0, 0, 2, 8'h00, 8'h05, 8'h05, "ovw_rd2");
        add(0, 1, 1, 8'h21, 8'h21, 8'h21, "same_a");
        add(0, 1, 1, 8'h22, 8'h22, 8'h22, "same_b");
        add(0, 0, 1, 8'h00, 8'h22, 8'h22, "same_rd");
        add(1, 1, 2, 8'hAA, 8'h00, 8'h00, "rst_pri");
        add(0, 0, 2, 8'h00, RP2, RP2, "rst_pri_rd");
        for (int i = 0; i < 6; i++)
            add(0, 1, 3'(i), 8'(8'h10 + i), 8'(8'h10 + i), 8'(8'h10 + i), "refill");
        add(0, 1, 7, 8'h66, 8'h66, 8'h00, "oor_wr7");
        add(0, 1, 6, 8'h55, 8'h55, 8'h00, "oor_wr6");
        add(0, 0, 6, 8'h00, 8'h55, 8'h00, "oor_rd6");
        add(0, 0, 7, 8'h00, 8'h66, 8'h00, "oor_rd7");
        for (int i = 0; i < 6; i++)
            add(0, 0, 3'(i), 8'h00, 8'(8'h10 + i), 8'(8'h10 + i), "oor_keep");

        foreach (vecs[i]) apply(vecs[i]);

        // Output holds between edges even while inputs toggle.
        v = '{r: 0, w: 0, a: 3'd4, d: 8'h00, e8: 8'h14, e6: 8'h14, nm: "hold"};
        apply(v);
        addr = 3'd0; we = 1'b1; wrdata = 8'hFF;
        #2;
        check("no_comb_path", 8'h14, 8'h14);

        // Two-cycle reset with a pending write, then resume.
        v = '{r: 1, w: 1, a: 3'd0, d: 8'hEE, e8: 8'h00, e6: 8'h00, nm: "rst_mid_a"};
        apply(v);
        v.nm = "rst_mid_b";
        apply(v);
        v = '{r: 0, w: 0, a: 3'd0, d: 8'h00, e8: RP0, e6: RP0, nm: "rst_mid_rd"};
        apply(v);
        v = '{r: 0, w: 1, a: 3'd5, d: 8'h5A, e8: 8'h5A, e6: 8'h5A, nm: "resume_wr"};
        apply(v);
        v = '{r: 0, w: 0, a: 3'd5, d: 8'h00, e8: 8'h5A, e6: 8'h5A, nm: "resume_rd"};
        apply(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/b64_memory_8x8.md
# b64_memory_8x8

Single-port, 64-bit (8 words × 8 bits) synchronous memory built from flops. It has one shared address bus, a write-enable, and a registered read-data output. It serves as a small register-file/scratchpad SRAM in the synthesis-flow designs and is clocked from the single system clock.

## Interface
- ADDR_WIDTH, 3: address bus width.
- DATA_WIDTH, 8: word width.
- DEPTH, 8: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- we  input  1  write enable; 1 = write `wrdata` to `addr` at this edge.
- addr  input  ADDR_WIDTH  word address, shared by read and write.
- wrdata  input  DATA_WIDTH  write data.
- rddata  output  DATA_WIDTH  registered read data.

## Operation
- Storage: DEPTH × DATA_WIDTH flop array, `mem[0..DEPTH-1]`.
- Every rising edge evaluates in this priority order:
  - **rst = 1:** `rddata` ← 0. The array is also cleared to 0 if `B64_MEMORY_RESET_CLEAR_EN` is defined (see Configuration). `we` is ignored.
  - **we = 1 and addr < DEPTH:** `mem[addr]` ← `wrdata`; `rddata` ← `wrdata` (write-through).
  - **we = 1 and addr ≥ DEPTH:** no array change; `rddata` ← 0.
  - **we = 0 and addr < DEPTH:** `rddata` ← `mem[addr]`.
  - **we = 0 and addr ≥ DEPTH:** `rddata` ← 0.
- A read happens on every non-reset edge. There is no separate read enable, so `rddata` always reflects the address sampled at the last edge.
- No other outputs, status flags, or error signalling.

## Timing
- `rddata` reset value: 0. Array contents after reset depend on the macro.
- Write latency: the value is stored at the rising edge where `we` = 1. A read of that address sampled at the next edge returns the new data.
- Read latency: 1 cycle. `addr` sampled at edge N gives `rddata` valid after edge N and held until edge N+1.
- Write-through: for the edge where `we` = 1, `rddata` shows `wrdata` after that edge, not the old contents.
- Back-to-back writes to different addresses on consecutive edges are all committed.
- Repeated writes to the same address: the last write wins.
- Reset mid-operation: a write coincident with `rst` = 1 is discarded. Operation resumes on the first edge with `rst` = 0.
- `rddata` is driven directly from a flop, with no combinational path from the inputs.

## Configuration
- Macro: `B64_MEMORY_RESET_CLEAR_EN`.
- **Defined:** synchronous reset clears every array word to 0, in addition to `rddata`. A read of any address after reset returns 0.
- **Not defined:** reset clears only `rddata`. Array words keep their pre-reset contents; power-up contents are undefined (X in simulation).

## Test plan
- Reset: hold `rst` = 1 for 4 edges with `we` = 0 and `addr` = 0 → `rddata` = 0x00. With the macro defined, reads of addresses 0–7 after reset each return 0x00.
- Sequential writes: write (0, 0x03), (1, 0x04), (2, 0x05), (3, 0x06) on consecutive edges → `rddata` after each edge equals the data just written.
- Read-back: with `we` = 0, read addresses 0, 1, 2, 3 on consecutive edges → `rddata` = 0x03, 0x04, 0x05, 0x06, each one cycle after its address.
- Overwrite: write (3, 0x07), then read 3, 1, 0 → 0x07, 0x04, 0x03; the other words are unaffected.
- Reset priority: assert `rst` = 1 together with `we` = 1, `addr` = 2, `wrdata` = 0xAA, then release and read 2 → returns 0x00 with the macro defined, 0x05 without it. `rddata` = 0 during reset in both cases.
- Out-of-range (DEPTH = 6 build): write (6, 0x55), then read 6 and 7 → `rddata` = 0x00; words 0–5 are unchanged.
